// File: rtl/riscv_multi_core.sv
// Multi-cycle RV32I/RV32E subset core with one shared memory port for fetch and data.
// Supported: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal; anything else traps.
module riscv_multi_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned RW   = $clog2(NREGS);
    localparam bit          RV32E = (NREGS == 16);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXR, EXI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       ir, pc_q, a_q, b_q, target_q, alu_q, mdr_q, addr_q, wdata_q;
    logic              trap_q;
    logic [CNT_W-1:0]  instret_q;
    logic [31:0]       rf [NREGS];

    // Instruction fields and immediates
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, bad_reg;
    logic use_rd, use_rs1, use_rs2;

    always_comb begin
        is_lw   = (opcode == OP_LOAD)  && (f3 == 3'b010);
        is_sw   = (opcode == OP_STORE) && (f3 == 3'b010);
        is_r    = (opcode == OP_R) &&
                  (((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                   ((f7 == 7'b0100000) && (f3 == 3'b000)));
        is_i    = (opcode == OP_I) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
        is_beq  = (opcode == OP_BR) && (f3 == 3'b000);
        is_jal  = (opcode == OP_JAL);
        use_rd  = is_lw | is_r | is_i | is_jal;
        use_rs1 = is_lw | is_sw | is_r | is_i | is_beq;
        use_rs2 = is_sw | is_r | is_beq;
        // Only fields an instruction actually uses are range-checked on RV32E
        bad_reg = RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
    end

    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, ea, pc_inc;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];
    assign pc_inc  = pc_q + 32'd4;
    assign ea      = a_q + (is_sw ? imm_s : imm_i);
    assign alu_b   = (state == EXR) ? b_q : imm_i;

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            3'b000:  alu_res = ((state == EXR) && f7[5]) ? (a_q - alu_b) : (a_q + alu_b);
            3'b111:  alu_res = a_q & alu_b;
            3'b110:  alu_res = a_q | alu_b;
            3'b010:  alu_res = {31'd0, ($signed(a_q) < $signed(alu_b))};
            default: alu_res = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    logic        req_c, rf_we, retire;
    logic [31:0] rf_wd;

    // Next state, memory strobes, write-back and retire
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        rf_we     = 1'b0;
        rf_wd     = alu_q;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                req_c    = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                if (bad_reg)               state_nxt = TRAP;
                else if (is_lw || is_sw)   state_nxt = MEMADR;
                else if (is_r)             state_nxt = EXR;
                else if (is_i)             state_nxt = EXI;
                else if (is_beq)           state_nxt = BEQ;
                else if (is_jal)           state_nxt = JAL;
                else                       state_nxt = TRAP;
            end
            MEMADR: begin
                if (ea[1:0] != 2'b00) state_nxt = TRAP;
                else if (is_lw)       state_nxt = MEMRD;
                else                  state_nxt = MEMWR;
            end
            MEMRD: begin
                req_c = 1'b1;
                if (mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                rf_we     = 1'b1;
                rf_wd     = mdr_q;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            MEMWR: begin
                req_c  = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            EXR, EXI: state_nxt = ALUWB;
            ALUWB: begin
                rf_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            BEQ: begin
                if ((a_q == b_q) && target_q[1]) begin
                    state_nxt = TRAP;
                end else begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            JAL: begin
                if (target_q[1]) begin
                    state_nxt = TRAP;
                end else begin
                    rf_we     = 1'b1;
                    rf_wd     = pc_inc;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = TRAP;
        endcase
    end

    // Request drops as soon as reset is low; fetch starts in the first cycle out of reset
    assign mem_req   = reset & req_c;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign trap      = trap_q;
    assign instret   = instret_q;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ir        <= 32'd0;
            trap_q    <= 1'b0;
            instret_q <= '0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            target_q  <= 32'd0;
            alu_q     <= 32'd0;
            mdr_q     <= 32'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            case (state)
                FETCH:  if (mem_ready) ir <= mem_rdata;
                DECODE: begin
                    a_q      <= rs1_val;
                    b_q      <= rs2_val;
                    target_q <= pc_q + (is_jal ? imm_j : imm_b);
                end
                MEMADR: begin
                    addr_q  <= ea;
                    wdata_q <= b_q;
                end
                MEMRD:        if (mem_ready) mdr_q <= mem_rdata;
                EXR, EXI:     alu_q <= alu_res;
                MEMWB, ALUWB: pc_q <= pc_inc;
                MEMWR:        if (mem_ready) pc_q <= pc_inc;
                BEQ:          if (state_nxt == FETCH) pc_q <= (a_q == b_q) ? target_q : pc_inc;
                JAL:          if (!target_q[1]) pc_q <= target_q;
                default: ;
            endcase
            if (retire)              instret_q <= instret_q + CNT_W'(1);
            if (state_nxt == TRAP)   trap_q    <= 1'b1;
        end
    end

    // Register file: x0 is never written and reads as zero
    always_ff @(posedge clk) begin
        if (reset && rf_we && (rd != 5'd0)) rf[rd[RW-1:0]] <= rf_wd;
    end

endmodule

// File: tb/tb_riscv_multi_core.sv
// Directed bench for riscv_multi_core: RV32I instance on a word memory with
// programmable wait states, plus an RV32E instance with a 2-bit retire counter.
module tb_riscv_multi_core;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        trap;
    logic [31:0] instret;

    logic        e_reset;
    logic        e_req, e_we, e_trap;
    logic [31:0] e_addr, e_wdata, e_pc, e_instr;
    logic [1:0]  e_instret;

    logic [31:0] mem [256];
    int          wait_n;
    int          cnt;
    int          wr_cnt;
    int          req_in_trap;
    int          wr_snap;
    logic [31:0] last_wa, last_wd;
    int          total, bad;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;

    riscv_multi_core #(.RESET_PC(32'h0), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .trap(trap), .instret(instret)
    );

    riscv_multi_core #(.RESET_PC(32'h100), .NREGS(16), .CNT_W(2)) dut_e (
        .clk(clk), .reset(e_reset),
        .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr), .mem_wdata(e_wdata),
        .mem_rdata(e_instr), .mem_ready(1'b1),
        .pc(e_pc), .trap(e_trap), .instret(e_instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && (cnt >= wait_n);

    // Memory model: wait-state counter, write port, write log and trap monitor
    always @(posedge clk) begin
        if (!mem_req || mem_ready) cnt <= 0;
        else                       cnt <= cnt + 1;
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (trap && mem_req) req_in_trap <= req_in_trap + 1;
        if (e_req && e_we)   wr_cnt <= wr_cnt + 100;
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1, input int off);
        logic [12:0] im;
        im = 13'(off);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input int off);
        logic [20:0] im;
        im = 21'(off);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; wait_n = 0; cnt = 0; wr_cnt = 0; req_in_trap = 0;
        last_wa = 32'd0; last_wd = 32'd0;
        reset = 1'b0; e_reset = 1'b0;
        e_instr = enc_i(OP_I, 5'd1, 3'b000, 5'd0, 1);
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
        mem[32'h00 >> 2] = enc_i(OP_I, 5'd1, 3'b000, 5'd0, 5);      // addi x1,x0,5
        mem[32'h04 >> 2] = enc_i(OP_I, 5'd2, 3'b000, 5'd0, -3);     // addi x2,x0,-3
        mem[32'h08 >> 2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);  // add x3,x1,x2
        mem[32'h0C >> 2] = enc_s(5'd3, 5'd0, 8);                    // sw x3,8(x0)
        mem[32'h10 >> 2] = enc_i(OP_L, 5'd4, 3'b010, 5'd0, 8);      // lw x4,8(x0)
        mem[32'h14 >> 2] = enc_s(5'd4, 5'd0, 32'h100);              // sw x4,0x100(x0)
        mem[32'h18 >> 2] = enc_i(OP_I, 5'd0, 3'b000, 5'd0, 7);      // addi x0,x0,7
        mem[32'h1C >> 2] = enc_s(5'd0, 5'd0, 32'h104);              // sw x0,0x104(x0)
        mem[32'h20 >> 2] = enc_b(5'd0, 5'd0, -8);                   // beq x0,x0,-8
        mem[32'h24 >> 2] = enc_j(5'd0, 32'h1C);                     // jal x0,+0x1C
        mem[32'h40 >> 2] = enc_j(5'd1, 12);                         // jal x1,+12
        mem[32'h4C >> 2] = enc_s(5'd1, 5'd0, 32'h108);              // sw x1,0x108
        mem[32'h50 >> 2] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd5);  // sub x5,x2,x1
        mem[32'h54 >> 2] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd6);  // slt x6,x2,x1
        mem[32'h58 >> 2] = enc_i(OP_I, 5'd7, 3'b010, 5'd1, -1);     // slti x7,x1,-1
        mem[32'h5C >> 2] = enc_i(OP_I, 5'd8, 3'b110, 5'd1, 3);      // ori x8,x1,3
        mem[32'h60 >> 2] = enc_r(7'h00, 5'd2, 5'd8, 3'b111, 5'd9);  // and x9,x8,x2
        mem[32'h64 >> 2] = enc_s(5'd5, 5'd0, 32'h10C);
        mem[32'h68 >> 2] = enc_s(5'd6, 5'd0, 32'h110);
        mem[32'h6C >> 2] = enc_s(5'd7, 5'd0, 32'h114);
        mem[32'h70 >> 2] = enc_s(5'd8, 5'd0, 32'h118);
        mem[32'h74 >> 2] = enc_s(5'd9, 5'd0, 32'h11C);
        mem[32'h78 >> 2] = enc_i(OP_L, 5'd5, 3'b010, 5'd0, 2);      // lw x5,2(x0)

        @(negedge clk);
        run(2);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("e_rst_pc", e_pc, 32'h100);
        chk("e_rst_wdata", e_wdata, 32'd0);

        reset = 1'b1;
        #1;
        chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("first_fetch_addr", mem_addr, 32'd0);
        chk("first_fetch_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        run(11);
        chk("alu3_pc", pc, 32'h0C);
        chk("alu3_instret", instret, 32'd3);

        wait_n = 2;
        run(6);
        chk("sw_hold_req", {31'd0, mem_req}, 32'd1);
        chk("sw_hold_we", {31'd0, mem_we}, 32'd1);
        chk("sw_hold_addr", mem_addr, 32'd8);
        chk("sw_hold_wdata", mem_wdata, 32'd2);
        chk("sw_hold_nowrite", 32'(wr_cnt), 32'd0);
        run(2);
        chk("sw_pc", pc, 32'h10);
        chk("sw_instret", instret, 32'd4);
        chk("sw_waddr", last_wa, 32'd8);
        chk("sw_wdata", last_wd, 32'd2);
        chk("sw_wcount", 32'(wr_cnt), 32'd1);
        run(9);
        chk("lw_pc", pc, 32'h14);
        chk("lw_instret", instret, 32'd5);

        wait_n = 0;
        run(4);
        chk("lw_value", mem[32'h100 >> 2], 32'd2);
        run(8);
        chk("x0_reads_zero", mem[32'h104 >> 2], 32'd0);
        chk("pre_beq_pc", pc, 32'h20);
        run(3);
        chk("beq_taken_pc", pc, 32'h18);
        chk("beq_taken_instret", instret, 32'd9);
        mem[32'h20 >> 2] = enc_b(5'd0, 5'd1, -8);                   // beq x1,x0,-8
        run(11);
        chk("beq_nt_pc", pc, 32'h24);
        chk("beq_nt_instret", instret, 32'd12);
        run(3);
        chk("jal0_pc", pc, 32'h40);
        run(3);
        chk("jal_pc", pc, 32'h4C);
        chk("jal_instret", instret, 32'd14);
        run(44);
        chk("block_pc", pc, 32'h78);
        chk("block_instret", instret, 32'd25);
        chk("jal_link", mem[32'h108 >> 2], 32'h44);
        chk("sub", mem[32'h10C >> 2], 32'hFFFF_FFB9);
        chk("slt", mem[32'h110 >> 2], 32'd1);
        chk("slti", mem[32'h114 >> 2], 32'd0);
        chk("ori", mem[32'h118 >> 2], 32'h47);
        chk("and", mem[32'h11C >> 2], 32'h45);

        run(6);
        chk("misalign_lw_trap", {31'd0, trap}, 32'd1);
        chk("misalign_lw_req", {31'd0, mem_req}, 32'd0);
        chk("misalign_lw_pc", pc, 32'h78);
        chk("misalign_lw_instret", instret, 32'd25);
        chk("trap_req_cycles", 32'(req_in_trap), 32'd0);

        // Reset during a stalled store
        reset = 1'b0;
        run(2);
        chk("rst2_trap", {31'd0, trap}, 32'd0);
        chk("rst2_instret", instret, 32'd0);
        mem[0] = enc_s(5'd0, 5'd0, 32'h120);
        mem[32'h120 >> 2] = 32'h1111_1111;
        wr_snap = wr_cnt;
        wait_n = 5;
        reset = 1'b1;
        run(8);
        chk("stall_wr_we", {31'd0, mem_we}, 32'd1);
        chk("stall_wr_addr", mem_addr, 32'h120);
        reset = 1'b0;
        run(1);
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_instret", instret, 32'd0);
        run(2);
        chk("abort_mem", mem[32'h120 >> 2], 32'h1111_1111);
        chk("abort_wcount", 32'(wr_cnt), 32'(wr_snap));

        mem[0] = 32'h0000_007F;
        wait_n = 0;
        reset = 1'b1;
        #1;
        chk("refetch_req", {31'd0, mem_req}, 32'd1);
        chk("refetch_addr", mem_addr, 32'd0);
        @(negedge clk);
        run(2);
        chk("illegal_trap", {31'd0, trap}, 32'd1);
        chk("illegal_pc", pc, 32'd0);

        reset = 1'b0;
        run(2);
        mem[0] = enc_b(5'd0, 5'd0, 6);                              // beq x0,x0,+6
        reset = 1'b1;
        run(4);
        chk("beq_misalign_trap", {31'd0, trap}, 32'd1);
        chk("beq_misalign_pc", pc, 32'd0);
        chk("beq_misalign_instret", instret, 32'd0);

        // RV32E instance: reset vector, counter wrap, high register index
        e_reset = 1'b1;
        #1;
        chk("e_fetch_addr", e_addr, 32'h100);
        @(negedge clk);
        run(19);
        chk("e_pc", e_pc, 32'h114);
        chk("e_instret_wrap", {30'd0, e_instret}, 32'd1);
        chk("e_no_trap", {31'd0, e_trap}, 32'd0);
        e_reset = 1'b0;
        run(1);
        e_instr = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd17);         // add x17,x0,x0
        e_reset = 1'b1;
        run(3);
        chk("e_x17_trap", {31'd0, e_trap}, 32'd1);
        chk("e_x17_pc", e_pc, 32'h100);
        chk("e_x17_instret", {30'd0, e_instret}, 32'd0);
        chk("e_no_writes", 32'(wr_cnt), 32'(wr_snap));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_multi_core.md
RISCV_MULTI_CORE -- requirements
Module: riscv_multi_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-002 SHALL have parameter NREGS, default 32, meaning the register count: 32 for RV32I, 16 for RV32E. Only 16 and 32 are legal.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port mem_req, output, 1 bit: memory request valid.
REQ-007 SHALL have port mem_we, output, 1 bit: 1 = word write, 0 = word read.
REQ-008 SHALL have port mem_addr, output, 32 bits: byte address.
REQ-009 SHALL have port mem_wdata, output, 32 bits: store data.
REQ-010 SHALL have port mem_rdata, input, 32 bits: read data, valid in the mem_ready cycle.
REQ-011 SHALL have port mem_ready, input, 1 bit: transfer completes on an edge where mem_req=1 and mem_ready=1.
REQ-012 SHALL have port pc, output, 32 bits: address of the instruction currently executing.
REQ-013 SHALL have port trap, output, 1 bit: sticky fault indicator.
REQ-014 SHALL have port instret, output, CNT_W bits: retired-instruction count.

Function
REQ-015 SHALL be a multi-cycle core using a single shared memory port for both fetch and data.
REQ-016 SHALL support: lw, sw; add, sub, and, or, slt (R-type); addi, andi, ori, slti; beq; jal. Every other opcode/funct SHALL be illegal.
REQ-017 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BEQ, JAL, TRAP.
REQ-018 FETCH SHALL hold mem_req=1, mem_we=0, mem_addr=pc until mem_ready; on ready it latches IR and goes to DECODE.
REQ-019 DECODE SHALL read rs1/rs2, compute pc+imm, then branch on opcode: lw/sw->MEMADR, R->EXR, I-ALU->EXI, beq->BEQ, jal->JAL, illegal->TRAP.
REQ-020 MEMADR SHALL compute rs1+imm; addr[1:0]!=0 -> TRAP; else lw->MEMRD, sw->MEMWR.
REQ-021 MEMRD/MEMWR SHALL hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ready. MEMRD latches mem_rdata -> MEMWB; MEMWR -> FETCH.
REQ-022 MEMWB, ALUWB and JAL SHALL write rd; writes to x0 SHALL be discarded; x0 SHALL read 0.
REQ-023 With NREGS=16, any rs1/rs2/rd index >= 16 SHALL be illegal (DECODE -> TRAP).
REQ-024 BEQ: if rs1==rs2, pc <= pc+imm, else pc <= pc+4; then FETCH.
REQ-025 JAL: rd <= pc+4, pc <= pc+imm; then FETCH.
REQ-026 A branch or jump target with bit 1 set SHALL go to TRAP with pc unchanged.
REQ-027 Non-branch instructions SHALL update pc <= pc+4 on their last state.
REQ-028 pc arithmetic SHALL wrap modulo 2^32.
REQ-029 slt/slti SHALL compare signed. sub SHALL be selected by funct7[5]=1 on R-type only.
REQ-030 instret SHALL increment by 1 on each instruction's final state (excluding TRAP) and wrap at 2^CNT_W.
REQ-031 Zero-wait latencies SHALL be: lw 5, sw 4, R/I-ALU 4, beq 3, jal 3 cycles.
REQ-032 Each extra cycle with mem_ready=0 SHALL add exactly one cycle.
REQ-033 mem_ready SHALL be ignored while mem_req=0.
REQ-034 mem_req SHALL be 0 in every state except FETCH, MEMRD and MEMWR.
REQ-035 TRAP SHALL set trap=1, keep mem_req=0, freeze pc, registers and instret, and be left only by reset.

Reset
REQ-036 While reset=0 at an edge: state <= FETCH, pc <= RESET_PC, trap <= 0, instret <= 0, IR <= 0, and mem_req is 0 from the next cycle.
REQ-037 General registers other than x0 SHALL NOT be reset.
REQ-038 Reset asserted mid-transfer SHALL abandon the transfer; no register write and no instret increment for it.
REQ-039 The first fetch after reset SHALL assert mem_req in the first cycle with reset=1.

Verification
REQ-040 addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2, zero wait -> x3=2, instret=3 after 12 cycles.
REQ-041 sw x3,8(x0) then lw x4,8(x0), mem_ready low for 2 cycles per transfer -> write of 2 at address 8; x4=2; lw takes 9 cycles.
REQ-042 beq x0,x0,-8 at pc=0x20 -> pc=0x18 after 3 cycles. beq with unequal operands -> pc=0x24.
REQ-043 jal x1,+12 at pc=0x40 -> x1=0x44, pc=0x4C. addi x0,x0,7 -> x0 still reads 0.
REQ-044 lw x5,2(x0) -> TRAP, trap=1, mem_req stays 0. Opcode 7'h7F -> TRAP. With NREGS=16, add x17,... -> TRAP.
REQ-045 Reset low during MEMWR with mem_ready=0 -> no write occurs; pc=RESET_PC; fetch restarts.
